// File: rtl/fifo_serial_tx_pkg.sv
// Shared state encoding and line-level constants for the FIFO serial transmitter.
package fifo_serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/tx_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the terminal count.
module tx_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tick = i_enable && !i_clear && (r_cnt == LAST);

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops words from the latch FIFO and sends each as start, LSB-first data, stop.
// Define FIFO_TX_PARITY_EN to insert an odd-parity bit after the MSB.
module fifo_serial_tx
    import fifo_serial_tx_pkg::*;
#(
    parameter int unsigned WIDTH        = 64,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     fifo_data,
    input  logic                 fifo_empty,
    input  logic                 tx_enable,
    output logic                 read_n,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 frame_done,
    output logic [CNT_WIDTH-1:0] words_sent
);

    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    tx_state_t            r_state;
    logic [WIDTH-1:0]     r_shift;
    logic [BW-1:0]        r_bit_cnt;
    logic                 r_read_n;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_done;
    logic [CNT_WIDTH-1:0] r_words;
`ifdef FIFO_TX_PARITY_EN
    logic                 r_parity;
`endif

    logic w_tick;
    logic w_clear;
    logic w_baud_en;
    logic w_can_pop;

    assign w_clear   = (r_state == POP);
    assign w_baud_en = (r_state == START) || (r_state == DATA) ||
                       (r_state == PARITY) || (r_state == STOP);
    // Only looked at in IDLE and at the end of STOP.
    assign w_can_pop = tx_enable && !fifo_empty;

    tx_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clear  (w_clear),
        .i_enable (w_baud_en),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_read_n  <= 1'b1;
            r_tx      <= LINE_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_words   <= '0;
`ifdef FIFO_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_can_pop) begin
                        r_state  <= POP;
                        r_read_n <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                POP: begin
                    // FIFO output settled on the intervening negedge.
                    r_shift   <= fifo_data;
`ifdef FIFO_TX_PARITY_EN
                    r_parity  <= ~^fifo_data;
`endif
                    r_read_n  <= 1'b1;
                    r_tx      <= START_BIT;
                    r_bit_cnt <= '0;
                    r_state   <= START;
                end
                START: begin
                    if (w_tick) begin
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit_cnt == LAST_BIT) begin
`ifdef FIFO_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= PARITY;
`else
                            r_tx    <= STOP_BIT;
                            r_state <= STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end
`ifdef FIFO_TX_PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        r_tx    <= STOP_BIT;
                        r_state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (w_tick) begin
                        r_done  <= 1'b1;
                        r_words <= r_words + 1'b1;
                        if (w_can_pop) begin
                            r_state  <= POP;
                            r_read_n <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_read_n <= 1'b1;
                    r_tx     <= LINE_IDLE;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign read_n     = r_read_n;
    assign tx_out     = r_tx;
    assign tx_busy    = r_busy;
    assign frame_done = r_done;
    assign words_sent = r_words;

endmodule

// File: doc/fifo_serial_tx.md
Name: fifo_serial_tx

Overview:
- Read-side consumer for the latch FIFO.
- Pops one word at a time using the FIFO's active-low read pulse and captures the FIFO's registered output.
- Serializes each word off-chip as an asynchronous frame: start bit, data LSB-first, optional parity, stop bit.
- Sits between the event FIFO and the chip's serial output pad.

Parameters:
- WIDTH, 64, bits per FIFO word and per frame payload.
- CLKS_PER_BIT, 4, clk cycles each serial bit is held (minimum 2).
- CNT_WIDTH, 16, width of the words_sent counter.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous reset, active low
- fifo_data  input  WIDTH  FIFO data_out; updated by FIFO on negedge clk while read_n low
- fifo_empty  input  1  FIFO empty flag (high = no word available)
- tx_enable  input  1  permits starting new frames
- read_n  output  1  FIFO pop request, active low, registered, one cycle wide
- tx_out  output  1  serial line; idle high
- tx_busy  output  1  high from pop through end of stop bit
- frame_done  output  1  one-cycle pulse at end of stop bit
- words_sent  output  CNT_WIDTH  count of completed frames, wraps

Behaviour:
- Reset (async, reset_n low): state IDLE, read_n=1, tx_out=1, tx_busy=0, frame_done=0, words_sent=0, shift register=0, all counters=0. Asserting reset mid-frame aborts the frame immediately, with tx_out forced high; no partial-frame completion.
- States: IDLE, POP, START, DATA, PARITY, STOP.
- IDLE: on a posedge with tx_enable=1 and fifo_empty=0, go to POP; read_n<=0 and tx_busy<=1 on the same edge.
- POP (exactly 1 cycle): FIFO loads data_out on the intervening negedge. On the next posedge:
  - shift_reg<=fifo_data; read_n<=1; tx_out<=0; go to START.
  - Latency: 1 clk from the IDLE decision edge to start-bit onset.
- Bit timing: a baud counter counts 0..CLKS_PER_BIT-1. Each bit is held exactly CLKS_PER_BIT cycles and advances when the counter reaches terminal count.
- START: after one bit period, tx_out<=shift_reg[0] and go to DATA.
- DATA: bit counter 0..WIDTH-1; shift right each bit period. After bit WIDTH-1, go to PARITY (feature on) or STOP.
- PARITY: tx_out = odd parity of the captured word, i.e. ~^word; held one bit period.
- STOP: tx_out=1 for one bit period. At its end:
  - frame_done pulses 1 cycle; words_sent increments modulo 2^CNT_WIDTH.
  - If tx_enable=1 and fifo_empty=0, go directly to POP (tx_busy stays 1). Otherwise go to IDLE with tx_busy<=0.
- Frame length: (WIDTH+2+P)*CLKS_PER_BIT cycles, where P=1 with the feature, else 0. Defaults with the feature give 268 cycles.
- tx_enable is sampled only in IDLE and at the end of STOP; deasserting it mid-frame finishes the current frame.
- fifo_empty is sampled only at those same points. The block never pulses read_n while fifo_empty=1, so no underflow pops.
- read_n is never low for more than one consecutive cycle. At most one pop is issued per frame.
- The block tolerates fifo_empty asserting during a frame, since the word has already been captured.

Optional Feature:
- Macro: FIFO_TX_PARITY_EN.
- Defined: the PARITY state is present and the odd-parity bit is inserted after the MSB.
- Undefined: the PARITY state is removed, STOP follows DATA directly, and the frame is WIDTH+2 bits.

Decomposition:
- Package fifo_serial_tx_pkg:
  - typedef enum tx_state_t {IDLE, POP, START, DATA, PARITY, STOP}
  - constants LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1
- Sub-module tx_baud_tick:
  - parameterized CLKS_PER_BIT counter with clear input and terminal-count tick output.
  - Cleared on the POP→START transition.

Test Plan:
- Reset behaviour: reset_n low with stimulus active → tx_out=1, read_n=1, words_sent=0. Release with fifo_empty=1 → line stays high indefinitely, read_n never pulses.
- Single word: WIDTH=8, CLKS_PER_BIT=2, feature on, word 8'hA5 → read_n low exactly 1 cycle; start bit 1 clk later.
  - Line is 0, 1,0,1,0,0,1,0,1 (LSB first), parity 1, stop 1, each held 2 cycles (22 cycles total).
  - frame_done pulses once; words_sent=1.
- Back-to-back: 3 words queued (8'h00, 8'hFF, 8'h3C) → no idle gap between stop bit and next start bit. Parities 1, 1, 1; words_sent=3; tx_busy continuously high.
- tx_enable drop mid-frame: deassert during DATA of word 1 with 2 words queued → word 1 completes, no further read_n pulse, tx_busy falls after stop. Re-enable → word 2 sent.
- Reset mid-frame: reset_n low during DATA bit 4 → tx_out high asynchronously, state IDLE. After release, the next queued word is popped and sent cleanly.
- Feature off (FIFO_TX_PARITY_EN undefined): 8'hA5 → 10-bit frame (20 cycles), no parity bit; stop immediately follows MSB.
